// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC capture controller.
package adc_pkg;

  localparam int unsigned ADC_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL_PRE  = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_FILL_POST = 3'd3,
    ST_DONE      = 3'd4
  } cap_state_t;

  typedef enum logic [1:0] {
    TM_FREE   = 2'd0,
    TM_RISE   = 2'd1,
    TM_FALL   = 2'd2,
    TM_SINGLE = 2'd3
  } trig_mode_t;

  // Level-crossing test between the previous and current accepted samples.
  function automatic logic trig_hit(
    input trig_mode_t       mode,
    input logic [ADC_W-1:0] prev,
    input logic [ADC_W-1:0] cur,
    input logic [ADC_W-1:0] lvl
  );
    case (mode)
      TM_FREE: return 1'b1;
      TM_FALL: return (prev > lvl) && (cur <= lvl);
      default: return (prev < lvl) && (cur >= lvl);
    endcase
  endfunction

endpackage

// File: rtl/adc_capture_ram.sv
// Double-buffered capture RAM: one write port, one registered read port.
// Address MSB selects the buffer.
module adc_capture_ram
  import adc_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [DEPTH_LOG2:0] i_waddr,
  input  logic [ADC_W-1:0]    i_wdata,
  input  logic [DEPTH_LOG2:0] i_raddr,
  output logic [ADC_W-1:0]    o_rdata
);

  logic [ADC_W-1:0] r_mem [2**(DEPTH_LOG2+1)];
  logic [ADC_W-1:0] r_rdata;

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/adc_capture_ctrl.sv
// Triggered ADC capture controller: decimation, level trigger with
// pre-trigger window, double-buffered capture swapped at frame boundaries.
module adc_capture_ctrl
  import adc_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADC_W-1:0]      adc_value,
  input  logic                  adc_valid,
  input  logic [ADC_W-1:0]      trig_level,
  input  logic [1:0]            trig_mode,
  input  logic [DEPTH_LOG2-1:0] pretrig,
  input  logic [3:0]            decim,
  input  logic                  arm,
  input  logic                  frame_done,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [ADC_W-1:0]      rd_data,
  output logic                  frame_valid,
  output logic                  triggered,
  output logic [2:0]            state
);

  cap_state_t            r_state;
  logic [3:0]            r_dec_cnt;
  logic [DEPTH_LOG2:0]   r_cnt;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_start;
  logic [DEPTH_LOG2-1:0] r_front_start;
  logic                  r_front_sel;
  logic                  r_frame_valid;
  logic                  r_triggered;
  logic [ADC_W-1:0]      r_prev;

  // Per-capture configuration, latched on entry to FILL_PRE.
  trig_mode_t            r_mode;
  logic [ADC_W-1:0]      r_level;
  logic [DEPTH_LOG2-1:0] r_pretrig;
  logic [3:0]            r_decim;

  logic                  w_accept;
  logic                  w_hit;
  logic                  w_we;
  logic                  w_wbuf;
  logic                  w_next_single;
  logic [DEPTH_LOG2-1:0] w_post_len;
  logic [DEPTH_LOG2:0]   w_cnt_inc;
  logic [DEPTH_LOG2:0]   w_pre_cnt;
  logic [DEPTH_LOG2-1:0] w_rd_phys;
  logic [ADC_W-1:0]      w_ram_q;

  assign w_accept      = adc_valid && (r_dec_cnt == 4'd0);
  assign w_hit         = trig_hit(r_mode, r_prev, adc_value, r_level);
  assign w_next_single = (trig_mode_t'(trig_mode) == TM_SINGLE);
  assign w_post_len    = ~r_pretrig;
  assign w_cnt_inc     = r_cnt + (DEPTH_LOG2+1)'(1);
  assign w_pre_cnt     = r_cnt + (DEPTH_LOG2+1)'(w_accept);
  assign w_rd_phys     = r_front_start + rd_addr;
  // In DONE the front select is about to flip, so the current front becomes
  // the back buffer of the capture that starts on the same edge.
  assign w_wbuf        = (r_state == ST_DONE) ? r_front_sel : ~r_front_sel;

  // Decimation counter: runs 0..decim on every valid strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_dec_cnt <= '0;
    end else if (adc_valid) begin
      if (r_dec_cnt >= r_decim) begin
        r_dec_cnt <= '0;
      end else begin
        r_dec_cnt <= r_dec_cnt + 4'd1;
      end
    end
  end

  // Back-buffer write enable for accepted samples in capturing states.
  always_comb begin
    w_we = 1'b0;
    case (r_state)
      ST_FILL_PRE, ST_WAIT_TRIG, ST_FILL_POST: w_we = w_accept;
      ST_DONE: w_we = w_accept && frame_done && !w_next_single;
      default: w_we = 1'b0;
    endcase
  end

  // Capture FSM, write pointer, trigger bookkeeping and buffer swap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= w_next_single ? ST_IDLE : ST_FILL_PRE;
      r_cnt         <= '0;
      r_wr_ptr      <= '0;
      r_start       <= '0;
      r_front_start <= '0;
      r_front_sel   <= 1'b0;
      r_frame_valid <= 1'b0;
      r_triggered   <= 1'b0;
      r_prev        <= '0;
      r_mode        <= trig_mode_t'(trig_mode);
      r_level       <= trig_level;
      r_pretrig     <= pretrig;
      r_decim       <= decim;
    end else begin
      if (w_we) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
        r_prev   <= adc_value;
      end
      case (r_state)
        ST_IDLE: begin
          if (arm) begin
            r_state   <= ST_FILL_PRE;
            r_cnt     <= '0;
            r_mode    <= trig_mode_t'(trig_mode);
            r_level   <= trig_level;
            r_pretrig <= pretrig;
            r_decim   <= decim;
          end
        end
        ST_FILL_PRE: begin
          if (w_accept) begin
            r_cnt <= w_cnt_inc;
          end
          if (w_pre_cnt >= {1'b0, r_pretrig}) begin
            r_state <= ST_WAIT_TRIG;
          end
        end
        ST_WAIT_TRIG: begin
          if (w_accept && w_hit) begin
            r_start     <= r_wr_ptr - r_pretrig;
            r_triggered <= 1'b1;
            r_cnt       <= '0;
            r_state     <= (w_post_len == '0) ? ST_DONE : ST_FILL_POST;
          end
        end
        ST_FILL_POST: begin
          if (w_accept) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == {1'b0, w_post_len}) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (frame_done) begin
            r_front_sel   <= ~r_front_sel;
            r_front_start <= r_start;
            r_frame_valid <= 1'b1;
            r_triggered   <= 1'b0;
            if (w_next_single) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else begin
              r_state   <= ST_FILL_PRE;
              r_cnt     <= (DEPTH_LOG2+1)'(w_accept);
              r_mode    <= trig_mode_t'(trig_mode);
              r_level   <= trig_level;
              r_pretrig <= pretrig;
              r_decim   <= decim;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  adc_capture_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr ({w_wbuf, r_wr_ptr}),
    .i_wdata (adc_value),
    .i_raddr ({r_front_sel, w_rd_phys}),
    .o_rdata (w_ram_q)
  );

  assign rd_data     = r_frame_valid ? w_ram_q : '0;
  assign frame_valid = r_frame_valid;
  assign triggered   = r_triggered;
  assign state       = r_state;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl: the driver queues expectations,
// a monitor compares them when the DUT presents read data or status.
module tb_adc_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] adc_value = '0;
  logic        adc_valid = 1'b0;
  logic [11:0] trig_level = 12'h800;
  logic [1:0]  trig_mode = 2'd1;
  logic [7:0]  pretrig = 8'd64;
  logic [3:0]  decim = 4'd0;
  logic        arm = 1'b0;
  logic        frame_done = 1'b0;
  logic [7:0]  rd_addr = '0;
  logic [11:0] rd_data;
  logic        frame_valid;
  logic        triggered;
  logic [2:0]  state;

  always #5 clk = ~clk;

  adc_capture_ctrl #(.DEPTH_LOG2(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .adc_value   (adc_value),
    .adc_valid   (adc_valid),
    .trig_level  (trig_level),
    .trig_mode   (trig_mode),
    .pretrig     (pretrig),
    .decim       (decim),
    .arm         (arm),
    .frame_done  (frame_done),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_valid (frame_valid),
    .triggered   (triggered),
    .state       (state)
  );

  typedef struct {
    string       name;
    logic [11:0] exp;
  } rd_exp_t;

  typedef struct {
    string       name;
    int          kind;   // 0 state, 1 frame_valid, 2 triggered
    logic [11:0] exp;
  } st_exp_t;

  rd_exp_t rd_q[$];
  st_exp_t st_q[$];
  int      n_chk = 0;
  int      n_fail = 0;
  logic    rd_req = 1'b0;
  logic    rd_pend = 1'b0;
  logic    st_req = 1'b0;

  // ---------------- monitor ----------------
  always @(posedge clk) rd_pend <= rd_req;

  always @(negedge clk) begin : monitor
    rd_exp_t     re;
    st_exp_t     se;
    logic [11:0] act;
    if (rd_pend) begin
      n_chk++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got 0x%03h with nothing queued", rd_data);
      end else begin
        re = rd_q.pop_front();
        if (rd_data !== re.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%03h, expected 0x%03h", re.name, rd_data, re.exp);
        end
      end
    end
    if (st_req) begin
      while (st_q.size() != 0) begin
        se = st_q.pop_front();
        case (se.kind)
          0:       act = {9'd0, state};
          1:       act = {11'd0, frame_valid};
          default: act = {11'd0, triggered};
        endcase
        n_chk++;
        if (act !== se.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%03h, expected 0x%03h", se.name, act, se.exp);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [11:0] v);
    adc_value = v;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    tick();
  endtask

  task automatic ramp_up(input int first, input int last);
    for (int i = first; i <= last; i++) send(12'(i * 16));
  endtask

  task automatic pulse_frame_done();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [11:0] e, input string nm);
    rd_exp_t x;
    x.name = nm;
    x.exp  = e;
    rd_q.push_back(x);
    rd_addr = a;
    rd_req  = 1'b1;
    tick();
    rd_req  = 1'b0;
  endtask

  task automatic expect_st(input int k, input logic [11:0] e, input string nm);
    st_exp_t x;
    x.name = nm;
    x.kind = k;
    x.exp  = e;
    st_q.push_back(x);
  endtask

  task automatic st_fire();
    st_req = 1'b1;
    tick();
    st_req = 1'b0;
  endtask

  task automatic status(input logic [2:0] s, input logic fv, input logic tr, input string nm);
    expect_st(0, {9'd0, s}, {nm, "_state"});
    expect_st(1, {11'd0, fv}, {nm, "_frame_valid"});
    expect_st(2, {11'd0, tr}, {nm, "_triggered"});
    st_fire();
  endtask

  task automatic do_reset(input logic [1:0] m, input logic [11:0] lvl,
                          input logic [7:0] pre, input logic [3:0] dec);
    trig_mode  = m;
    trig_level = lvl;
    pretrig    = pre;
    decim      = dec;
    reset_n    = 1'b0;
    tick();
    tick();
    reset_n    = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tick();

    // Reset, rising trigger at 0x800, pretrig 64
    do_reset(2'd1, 12'h800, 8'd64, 4'd0);
    status(3'd1, 1'b0, 1'b0, "rst");
    rd(8'd0, 12'h000, "rst_rd_data");
    ramp_up(0, 329);
    status(3'd4, 1'b0, 1'b1, "rise_done");
    pulse_frame_done();
    status(3'd1, 1'b1, 1'b0, "rise_swap");
    rd(8'd64,  12'h800, "rise_rd64");
    rd(8'd63,  12'h7F0, "rise_rd63");
    rd(8'd0,   12'h400, "rise_rd0");
    rd(8'd255, 12'h3F0, "rise_rd255");

    // frame_done outside DONE keeps the displayed buffer
    pulse_frame_done();
    status(3'd1, 1'b1, 1'b0, "fd_ignored");
    rd(8'd64, 12'h800, "fd_ignored_rd64");

    // Reset in FILL_POST aborts and clears the display
    ramp_up(0, 130);
    status(3'd3, 1'b1, 1'b1, "post");
    reset_n = 1'b0;
    tick();
    status(3'd1, 1'b0, 1'b0, "midrst");
    rd(8'd64, 12'h000, "midrst_rd_data");
    reset_n = 1'b1;

    // Falling trigger from 0xFFF at 0x400, pretrig 16
    do_reset(2'd2, 12'h400, 8'd16, 4'd0);
    for (int i = 0; i < 340; i++) send(12'hFFF - 12'(i * 32));
    status(3'd4, 1'b0, 1'b1, "fall_done");
    pulse_frame_done();
    status(3'd1, 1'b1, 1'b0, "fall_swap");
    rd(8'd16,  12'h3FF, "fall_rd16");
    rd(8'd15,  12'h41F, "fall_rd15");
    rd(8'd0,   12'h5FF, "fall_rd0");
    rd(8'd255, 12'h61F, "fall_rd255");

    // Free-run with decimation by 4
    do_reset(2'd0, 12'h800, 8'd8, 4'd3);
    for (int k = 0; k <= 1030; k++) send(12'(k));
    status(3'd4, 1'b0, 1'b1, "dec_done");
    pulse_frame_done();
    status(3'd1, 1'b1, 1'b0, "dec_swap");
    rd(8'd0,   12'h000, "dec_rd0");
    rd(8'd8,   12'h020, "dec_rd8");
    rd(8'd100, 12'h190, "dec_rd100");
    rd(8'd255, 12'h3FC, "dec_rd255");

    // Single-shot, pretrig 0
    do_reset(2'd3, 12'h800, 8'd0, 4'd0);
    status(3'd0, 1'b0, 1'b0, "ss_rst");
    for (int i = 0; i < 5; i++) send(12'hABC);
    status(3'd0, 1'b0, 1'b0, "ss_idle");
    pulse_arm();
    status(3'd1, 1'b0, 1'b0, "ss_armed");
    ramp_up(0, 389);
    status(3'd4, 1'b0, 1'b1, "ss_done");
    pulse_frame_done();
    status(3'd0, 1'b1, 1'b0, "ss_swap");
    rd(8'd0,   12'h800, "ss_rd0");
    rd(8'd1,   12'h810, "ss_rd1");
    rd(8'd255, 12'h7F0, "ss_rd255");
    pulse_frame_done();
    status(3'd0, 1'b1, 1'b0, "ss_noswap");
    rd(8'd0, 12'h800, "ss_noswap_rd0");

    // Re-arm with pretrig 255; pointer wraps through 255->0
    pretrig = 8'd255;
    pulse_arm();
    status(3'd1, 1'b1, 1'b0, "ss2_armed");
    for (int j = 0; j <= 390; j++) send(12'(j * 16));
    status(3'd4, 1'b1, 1'b1, "ss2_done");
    pulse_arm();
    status(3'd4, 1'b1, 1'b1, "ss2_arm_in_done");
    pulse_frame_done();
    status(3'd0, 1'b1, 1'b0, "ss2_swap");
    rd(8'd255, 12'h800, "ss2_rd255");
    rd(8'd254, 12'h7F0, "ss2_rd254");
    rd(8'd0,   12'h810, "ss2_rd0");

    idle(4);
    n_chk++;
    if (rd_q.size() != 0 || st_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d reads and %0d status checks left, expected 0", rd_q.size(), st_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
